// File: rtl/prog_loader_if.sv
// prog_loader_if: groups the loader's host-side word stream and its
// instruction-memory write port into a single bundle.
//   s_valid / s_data / s_last / s_ready : host -> loader instruction stream
//   imem_we / imem_addr / imem_wdata    : loader -> instruction-memory write port
// Modports:
//   master : host side (drives the stream, observes the memory writes)
//   slave  : loader side (accepts the stream, drives the memory writes)
interface prog_loader_if #(
   parameter int AW = 8,
   parameter int IW = 9
);
   logic          s_valid;
   logic [IW-1:0] s_data;
   logic          s_last;
   logic          s_ready;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [IW-1:0] imem_wdata;

   modport master (
      output s_valid, s_data, s_last,
      input  s_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      input  s_valid, s_data, s_last,
      output s_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: streams a program image into instruction memory, then boots
// the CPU and measures how many cycles it runs before halting.
// Ports:
//   CLK          clock, all state updates on the rising edge
//   reset_n      synchronous active-low reset
//   load_req     pulse that starts a new load (only honoured in IDLE/DONE)
//   bus          stream in + instruction-memory write port (slave side)
//   cpu_start    CPU init/hold; low only while the program runs
//   cpu_halt     CPU halt indication, only looked at while running
//   busy         high while loading, booting or running
//   done         high once the run (or an overflowed load) has finished
//   overflow     sticky flag: the image was larger than the memory
//   words_loaded words written by the current/last load
//   run_cycles   cycles between the cpu_start fall and cpu_halt
// All outputs come straight from flops.
module prog_loader #(
   parameter int AW           = 8,
   parameter int IW           = 9,
   parameter int START_CYCLES = 2,   // must be >= 1
   parameter int CW           = 16
) (
   input  logic          CLK,
   input  logic          reset_n,
   input  logic          load_req,
   prog_loader_if.slave  bus,
   output logic          cpu_start,
   input  logic          cpu_halt,
   output logic          busy,
   output logic          done,
   output logic          overflow,
   output logic [AW:0]   words_loaded,
   output logic [CW-1:0] run_cycles
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      BOOT,
      RUN,
      DONE
   } state_t;

   localparam int          BW   = (START_CYCLES < 2) ? 1 : $clog2(START_CYCLES + 1);
   localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};   // 2**AW words

   state_t          state_q, state_d;
   logic            start_q, start_d;
   logic            ready_q, ready_d;
   logic            we_q, we_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [IW-1:0]   wdata_q, wdata_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            ovf_q, ovf_d;
   logic [AW:0]     cnt_q, cnt_d;
   logic [CW-1:0]   run_q, run_d;
   logic [BW-1:0]   boot_q, boot_d;

   // NOTE: state flops use non-blocking assignments so every flop samples
   // the pre-edge value of every other flop.
   always_ff @(posedge CLK) begin
      if (!reset_n) begin
         state_q <= IDLE;
         start_q <= 1'b1;
         ready_q <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
         run_q   <= '0;
         boot_q  <= '0;
      end else begin
         state_q <= state_d;
         start_q <= start_d;
         ready_q <= ready_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
         run_q   <= run_d;
         boot_q  <= boot_d;
      end
   end

   // NOTE: every signal gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;
      run_d   = run_q;
      boot_d  = boot_q;

      unique case (state_q)
         IDLE, DONE: begin
            if (load_req) begin
               state_d = LOAD;
               cnt_d   = '0;
               ovf_d   = 1'b0;
               run_d   = '0;
            end
         end
         LOAD: begin
            if (bus.s_valid && ready_q) begin
               if (cnt_q == FULL) begin
                  // Memory already full: drop the word, keep draining.
                  ovf_d = 1'b1;
               end else begin
                  we_d    = 1'b1;
                  addr_d  = cnt_q[AW-1:0];
                  wdata_d = bus.s_data;
                  cnt_d   = cnt_q + 1'b1;
               end
               if (bus.s_last) begin
                  if (cnt_q == FULL) begin
                     state_d = DONE;            // never boot a truncated image
                  end else begin
                     state_d = BOOT;
                     boot_d  = BW'(1);          // first BOOT cycle counts
                  end
               end
            end
         end
         BOOT: begin
            if (boot_q == BW'(START_CYCLES)) begin
               state_d = RUN;
            end else begin
               boot_d = boot_q + 1'b1;
            end
         end
         RUN: begin
            if (cpu_halt) begin
               state_d = DONE;                  // halt cycle is not counted
            end else if (run_q != '1) begin
               run_d = run_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Registered outputs are decoded from the state being entered.
      start_d = (state_d != RUN);
      ready_d = (state_d == LOAD);
      busy_d  = (state_d == LOAD) || (state_d == BOOT) || (state_d == RUN);
      done_d  = (state_d == DONE);
   end

   assign bus.s_ready    = ready_q;
   assign bus.imem_we    = we_q;
   assign bus.imem_addr  = addr_q;
   assign bus.imem_wdata = wdata_q;
   assign cpu_start      = start_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign overflow       = ovf_q;
   assign words_loaded   = cnt_q;
   assign run_cycles     = run_q;

endmodule
